// File: rtl/dpwm_generador.sv
// rtl/dpwm_generador.sv - DPWM generator with synchronised, stability-filtered setpoint
// Duty setpoint is double-synchronised, accepted only when stable, and applied at period wraps.
module dpwm_generador #(
  parameter int PERIODO = 1000,
  parameter int ANCHO   = 10,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ANCHO-1:0] cant_corriente,
  output logic             pwm_out,
  output logic             fin_periodo,
  output logic [ANCHO-1:0] duty_actual
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ANCHO-1:0] PER_W  = ANCHO'(PERIODO);
  localparam logic [ANCHO-1:0] PER_M1 = ANCHO'(PERIODO - 1);
  localparam logic [PW-1:0]    DIV_M1 = PW'(DIV - 1);

  logic [ANCHO-1:0] s1_q, s1_d;
  logic [ANCHO-1:0] s2_q, s2_d;
  logic [ANCHO-1:0] duty_estable_q, duty_estable_d;
  logic [ANCHO-1:0] duty_sombra_q, duty_sombra_d;
  logic [ANCHO-1:0] contador_q, contador_d;
  logic [PW-1:0]    prescaler_q, prescaler_d;
  logic             pwm_q, pwm_d;
  logic             fin_q, fin_d;
  logic             tick;

  assign tick = (prescaler_q == DIV_M1);

  always_comb begin
    s1_d           = cant_corriente;
    s2_d           = s1_q;
    // A bus still moving between the two sync stages is never accepted
    duty_estable_d = (s1_q == s2_q) ? s2_q : duty_estable_q;
    prescaler_d    = prescaler_q;
    contador_d     = contador_q;
    duty_sombra_d  = duty_sombra_q;
    fin_d          = 1'b0;
    pwm_d          = 1'b0;
    if (enable) begin
      pwm_d = (contador_q < duty_sombra_q);
      if (tick) begin
        prescaler_d = '0;
        if (contador_q == PER_M1) begin
          contador_d    = '0;
          duty_sombra_d = (duty_estable_q > PER_W) ? PER_W : duty_estable_q;
          fin_d         = 1'b1;
        end else begin
          contador_d = contador_q + ANCHO'(1);
        end
      end else begin
        prescaler_d = prescaler_q + PW'(1);
      end
    end else begin
      prescaler_d = '0;
      contador_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q           <= '0;
      s2_q           <= '0;
      duty_estable_q <= '0;
      duty_sombra_q  <= '0;
      contador_q     <= '0;
      prescaler_q    <= '0;
      pwm_q          <= 1'b0;
      fin_q          <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      duty_estable_q <= duty_estable_d;
      duty_sombra_q  <= duty_sombra_d;
      contador_q     <= contador_d;
      prescaler_q    <= prescaler_d;
      pwm_q          <= pwm_d;
      fin_q          <= fin_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign fin_periodo = fin_q;
  assign duty_actual = duty_sombra_q;

endmodule

// File: tb/tb_dpwm_generador.sv
// tb/tb_dpwm_generador.sv - directed self-checking bench for dpwm_generador
// Runs a DIV=1 and a DIV=4 instance side by side from shared stimulus.
module tb_dpwm_generador;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [9:0] cant;
  logic       pwm, fin, pwm4, fin4;
  logic [9:0] duty, duty4;

  int tests_run;
  int tests_failed;

  dpwm_generador #(.PERIODO(1000), .ANCHO(10), .DIV(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cant_corriente(cant),
    .pwm_out(pwm), .fin_periodo(fin), .duty_actual(duty)
  );

  dpwm_generador #(.PERIODO(1000), .ANCHO(10), .DIV(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .cant_corriente(cant),
    .pwm_out(pwm4), .fin_periodo(fin4), .duty_actual(duty4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // From a fin_periodo cycle, count clks (and pwm-high clks) up to and including the next one
  task automatic measure_period(output int high, output int len);
    high = 0;
    len  = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      len++;
      if (pwm) high++;
      if (fin) break;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    cant   = 10'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pwm !== 1'b0 || fin !== 1'b0 || duty !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_state: pwm=%0b fin=%0b duty=%0d, required 0/0/0", pwm, fin, duty);
    end
    tests_run++;
    if (pwm4 !== 1'b0 || fin4 !== 1'b0 || duty4 !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_state_div4: pwm=%0b fin=%0b duty=%0d, required 0/0/0", pwm4, fin4, duty4);
    end
  endtask

  task automatic test_basic();
    int high, len;
    cant   = 10'd500;
    enable = 1'b1;
    reset  = 1'b1;
    measure_period(high, len);
    tests_run++;
    if (len !== 1000 || high !== 0) begin
      tests_failed++;
      $display("FAIL first_wrap: len=%0d high=%0d, required 1000/0", len, high);
    end
    tests_run++;
    if (duty !== 10'd500) begin
      tests_failed++;
      $display("FAIL first_duty: duty=%0d, required 500", duty);
    end
    measure_period(high, len);
    tests_run++;
    if (len !== 1000 || high !== 500) begin
      tests_failed++;
      $display("FAIL period_500: len=%0d high=%0d, required 1000/500", len, high);
    end
  endtask

  task automatic test_mid_change();
    int high, len;
    logic [9:0] duty_before;
    high = 0;
    len  = 0;
    duty_before = 10'd0;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk);
      if (i == 200) cant = 10'd550;
      if (!fin) duty_before = duty;
      len++;
      if (pwm) high++;
      if (fin) break;
    end
    tests_run++;
    if (high !== 500 || duty_before !== 10'd500) begin
      tests_failed++;
      $display("FAIL mid_change_current: high=%0d duty_before=%0d, required 500/500", high, duty_before);
    end
    tests_run++;
    if (duty !== 10'd550) begin
      tests_failed++;
      $display("FAIL mid_change_load: duty=%0d, required 550", duty);
    end
    measure_period(high, len);
    tests_run++;
    if (len !== 1000 || high !== 550) begin
      tests_failed++;
      $display("FAIL period_550: len=%0d high=%0d, required 1000/550", len, high);
    end
  endtask

  task automatic test_extremes();
    int high, len;
    cant = 10'd0;
    measure_period(high, len);
    tests_run++;
    if (duty !== 10'd0) begin
      tests_failed++;
      $display("FAIL duty0_load: duty=%0d, required 0", duty);
    end
    measure_period(high, len);
    tests_run++;
    if (high !== 0 || len !== 1000) begin
      tests_failed++;
      $display("FAIL duty0_period: high=%0d len=%0d, required 0/1000", high, len);
    end
    cant = 10'd1000;
    measure_period(high, len);
    tests_run++;
    if (duty !== 10'd1000) begin
      tests_failed++;
      $display("FAIL duty1000_load: duty=%0d, required 1000", duty);
    end
    for (int p = 0; p < 2; p++) begin
      measure_period(high, len);
      tests_run++;
      if (high !== 1000 || len !== 1000) begin
        tests_failed++;
        $display("FAIL duty1000_period%0d: high=%0d len=%0d, required 1000/1000", p, high, len);
      end
    end
    cant = 10'd200;
    measure_period(high, len);
    tests_run++;
    if (duty !== 10'd200) begin
      tests_failed++;
      $display("FAIL duty200_load: duty=%0d, required 200", duty);
    end
    cant = 10'd1023;
    measure_period(high, len);
    tests_run++;
    if (duty !== 10'd1000) begin
      tests_failed++;
      $display("FAIL saturate_1023: duty=%0d, required 1000", duty);
    end
  endtask

  task automatic test_toggle();
    int high, len, fins;
    logic [9:0] duty_at_fin;
    fins = 0;
    duty_at_fin = 10'd0;
    repeat (970) @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      cant = (k % 2 == 0) ? 10'd100 : 10'd900;
      @(negedge clk);
      if (fin) begin
        fins++;
        duty_at_fin = duty;
      end
    end
    tests_run++;
    if (fins !== 1 || duty_at_fin !== 10'd1000) begin
      tests_failed++;
      $display("FAIL toggle_ignored: wraps=%0d duty=%0d, required 1/1000", fins, duty_at_fin);
    end
    cant = 10'd300;
    measure_period(high, len);
    tests_run++;
    if (duty !== 10'd300) begin
      tests_failed++;
      $display("FAIL toggle_hold_300: duty=%0d, required 300", duty);
    end
  endtask

  task automatic test_enable();
    int high, len, bad;
    cant = 10'd700;
    measure_period(high, len);
    measure_period(high, len);
    tests_run++;
    if (high !== 700) begin
      tests_failed++;
      $display("FAIL period_700: high=%0d, required 700", high);
    end
    repeat (400) @(negedge clk);
    tests_run++;
    if (pwm !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_disable_pwm: pwm=%0b, required 1", pwm);
    end
    enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pwm !== 1'b0) begin
      tests_failed++;
      $display("FAIL disable_pwm: pwm=%0b, required 0", pwm);
    end
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (pwm !== 1'b0 || fin !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL disable_hold: bad_clks=%0d, required 0", bad);
    end
    enable = 1'b1;
    measure_period(high, len);
    tests_run++;
    if (len !== 1000 || high !== 700) begin
      tests_failed++;
      $display("FAIL reenable_period: len=%0d high=%0d, required 1000/700", len, high);
    end
  endtask

  task automatic test_async_reset_div4();
    int high, len;
    bit seen;
    repeat (100) @(negedge clk);
    tests_run++;
    if (pwm !== 1'b1 || duty !== 10'd700) begin
      tests_failed++;
      $display("FAIL pre_reset: pwm=%0b duty=%0d, required 1/700", pwm, duty);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (pwm !== 1'b0 || fin !== 1'b0 || duty !== 10'd0 || duty4 !== 10'd0) begin
      tests_failed++;
      $display("FAIL async_reset: pwm=%0b fin=%0b duty=%0d duty4=%0d, required 0/0/0/0",
               pwm, fin, duty, duty4);
    end
    @(negedge clk);
    reset = 1'b1;
    measure_period(high, len);
    tests_run++;
    if (len !== 1000 || high !== 0 || duty !== 10'd700) begin
      tests_failed++;
      $display("FAIL post_reset_period: len=%0d high=%0d duty=%0d, required 1000/0/700", len, high, duty);
    end
    seen = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (fin4) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL div4_first_wrap: no fin_periodo within 10000 clks, required one");
    end
    @(negedge clk);
    tests_run++;
    if (fin4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL div4_fin_width: fin=%0b one clk after pulse, required 0", fin4);
    end
    len = 1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      len++;
      if (fin4) break;
    end
    tests_run++;
    if (len !== 4000 || duty4 !== 10'd700) begin
      tests_failed++;
      $display("FAIL div4_period: len=%0d duty=%0d, required 4000/700", len, duty4);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_mid_change();
    test_extremes();
    test_toggle();
    test_enable();
    test_async_reset_div4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dpwm_generador.md
Name: dpwm_generador

Overview:
Downstream stage of the 10-bit up/down current-setpoint counter. Consumes the 10-bit setpoint `cant_corriente` (0..1000, steps of 50) and produces the DPWM output whose duty cycle equals setpoint/PERIODO. The setpoint bus is driven from button-edge-clocked logic and is asynchronous to `clk`. This block therefore synchronises it, filters it for stability and applies it only at period boundaries (glitch-free duty updates).

Parameters:
PERIODO, 1000, PWM period in ticks; counter runs 0..PERIODO-1; duty saturates at PERIODO (100 %)
ANCHO, 10, width of setpoint bus and period counter; must satisfy 2^ANCHO > PERIODO
DIV, 1, prescaler: one PWM tick every DIV clk cycles (DIV >= 1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  synchronous run enable; 0 = output held off
cant_corriente  input  ANCHO  duty setpoint from up/down counter, asynchronous to clk
pwm_out  output  1  registered PWM output
fin_periodo  output  1  one-clk pulse on every period wrap
duty_actual  output  ANCHO  duty value currently applied (shadow register)

Behaviour:
- Reset (reset=0, async): s1, s2, duty_estable, duty_sombra, contador, prescaler all 0. pwm_out=0, fin_periodo=0, duty_actual=0.
- Input sync: each clk, s1<=cant_corriente and s2<=s1. If s1==s2, duty_estable<=s2; otherwise duty_estable holds. A stable input reaches duty_estable 3 clks after change. A bus changing every clk never updates duty_estable.
- Prescaler: counts 0..DIV-1 while enable=1. tick=1 when prescaler==DIV-1. With DIV=1, tick is always 1.
- Period counter on tick:
  - If contador==PERIODO-1: contador<=0, duty_sombra<=min(duty_estable,PERIODO), fin_periodo<=1 for exactly one clk.
  - Otherwise: contador<=contador+1.
- Shadow saturation: duty_estable>PERIODO loads PERIODO. Values 1001..1023 give 100 % duty.
- fin_periodo is 0 on every clk not described above.
- pwm_out register: each clk, pwm_out<=enable & (contador<duty_sombra). This is one clk behind contador.
- Duty extremes:
  - duty 0: pwm_out constantly 0.
  - duty PERIODO: pwm_out constantly 1 across wraps (no 1-tick gap).
- Duty changes mid-period never affect the current period. They take effect from contador==0 of the next period.
- enable=0 (synchronous): prescaler<=0, contador<=0, pwm_out<=0, fin_periodo<=0. The sync and duty_estable pipeline keeps running. duty_sombra holds.
- enable 0->1: counting resumes from contador=0 using the held duty_sombra. The first wrap loads the new duty.
- Reset mid-period: immediate return to reset state. After release, the first period uses duty 0; the new setpoint is applied at the first wrap.
- duty_actual=duty_sombra (continuous assign).

Test Plan:
1. Reset, then cant_corriente=500, enable=1, DIV=1 -> duty_actual=500 after the first wrap (clk ~1001). Each following 1000-clk period: pwm_out high exactly 500 clks. fin_periodo pulses once per 1000 clks.
2. Change 500->550 at contador=200 -> current period keeps 500 high clks. Next period has 550 high clks. duty_actual changes on the fin_periodo clk.
3. Setpoint 0 then 1000 -> pwm_out 0 for a full period, then constant 1 across ≥2 wraps with no low clk. Force 1023 -> duty_actual=1000.
4. Toggle cant_corriente every clk between 100 and 900 for 50 clks, then hold 300 -> duty_estable ignores the toggling. duty_actual=300 at the next wrap after the hold.
5. enable=0 at contador=400 for 20 clks -> pwm_out=0 the next clk and fin_periodo stays 0. After re-enable, contador restarts at 0 and the period length is 1000 clks again.
6. reset=0 asserted asynchronously mid-period (between clk edges) -> pwm_out, fin_periodo and duty_actual go 0 immediately without a clk edge. Also run DIV=4: period = 4000 clks and fin_periodo is still 1 clk wide.
